// File: rtl/board_io_conditioner.sv
// rtl/board_io_conditioner.sv - board pin front end: sync/debounce, button irqs, reset stretch, LED PWM
module board_io_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int NUM_SW          = 16,
  parameter int NUM_LED         = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_BTN-1:0]  btn_i,
  input  logic [NUM_SW-1:0]   sw_i,
  input  logic [NUM_BTN-1:0]  irq_mask_i,
  input  logic [NUM_BTN-1:0]  irq_ack_i,
  input  logic [NUM_LED-1:0]  led_i,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic                soc_rst_o,
  output logic [NUM_BTN-1:0]  btn_o,
  output logic [NUM_BTN-1:0]  btn_rise_o,
  output logic [NUM_BTN-1:0]  irq_pending_o,
  output logic                irq_o,
  output logic [NUM_SW-1:0]   sw_o,
  output logic                sw_change_o,
  output logic [NUM_LED-1:0]  led_o
);

  localparam int NCH = NUM_BTN + NUM_SW;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(RST_HOLD_CYCLES + 1);

  // Buttons occupy the low channel indices, switches the high ones.
  logic [NCH-1:0]         w_raw;
  logic [NCH-1:0]         w_sync;
  logic [NCH-1:0]         w_flip;
  logic [NCH-1:0]         r_stable;
  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [CW-1:0]          r_cnt  [NCH];

  assign w_raw = {sw_i, btn_i};

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign w_sync[g] = r_sync[g][SYNC_STAGES-1];
    assign w_flip[g] = (w_sync[g] != r_stable[g]) && (r_cnt[g] == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sync[g] <= '0;
        r_cnt[g]  <= '0;
      end else begin
        r_sync[g] <= {r_sync[g][SYNC_STAGES-2:0], w_raw[g]};
        if ((w_sync[g] != r_stable[g]) && !w_flip[g])
          r_cnt[g] <= r_cnt[g] + CW'(1);
        else
          r_cnt[g] <= '0;
      end
    end
  end

  logic [NUM_BTN-1:0] w_btn_set;
  logic [NUM_BTN-1:0] r_rise;
  logic [NUM_BTN-1:0] r_pend;
  logic               r_sw_change;

  assign w_btn_set = w_flip[NUM_BTN-1:0] & w_sync[NUM_BTN-1:0];

  // The set term spans the rise cycle too, so an ack seen alongside btn_rise_o loses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stable    <= '0;
      r_rise      <= '0;
      r_pend      <= '0;
      r_sw_change <= 1'b0;
    end else begin
      r_stable    <= r_stable ^ w_flip;
      r_rise      <= w_btn_set;
      r_pend      <= w_btn_set | r_rise | (r_pend & ~irq_ack_i);
      r_sw_change <= |w_flip[NCH-1:NUM_BTN];
    end
  end

  logic [HW-1:0] r_hold;
  logic          r_soc_rst;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold    <= '0;
      r_soc_rst <= 1'b1;
    end else if (r_soc_rst) begin
      r_hold <= r_hold + HW'(1);
      if (r_hold == HW'(RST_HOLD_CYCLES - 1))
        r_soc_rst <= 1'b0;
    end
  end

  logic [PWM_BITS-1:0] r_pwm;
  logic [NUM_LED-1:0]  r_led;
  logic                w_pwm_on;

  assign w_pwm_on = (brightness_i == {PWM_BITS{1'b1}}) || (r_pwm < brightness_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm <= '0;
      r_led <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      r_led <= led_i & {NUM_LED{w_pwm_on}};
    end
  end

  assign soc_rst_o     = r_soc_rst;
  assign btn_o         = r_stable[NUM_BTN-1:0];
  assign sw_o          = r_stable[NCH-1:NUM_BTN];
  assign btn_rise_o    = r_rise;
  assign irq_pending_o = r_pend;
  assign irq_o         = |(r_pend & irq_mask_i);
  assign sw_change_o   = r_sw_change;
  assign led_o         = r_led;

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb/tb_board_io_conditioner.sv - directed self-checking bench for board_io_conditioner
module tb_board_io_conditioner;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] btn_i;
  logic [3:0] sw_i;
  logic [1:0] irq_mask_i;
  logic [1:0] irq_ack_i;
  logic [3:0] led_i;
  logic [2:0] brightness_i;
  logic       soc_rst_o;
  logic [1:0] btn_o;
  logic [1:0] btn_rise_o;
  logic [1:0] irq_pending_o;
  logic       irq_o;
  logic [3:0] sw_o;
  logic       sw_change_o;
  logic [3:0] led_o;

  int n_total = 0;
  int n_pass  = 0;

  board_io_conditioner #(
    .NUM_BTN(2), .NUM_SW(4), .NUM_LED(4), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .RST_HOLD_CYCLES(8), .PWM_BITS(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i), .sw_i(sw_i),
    .irq_mask_i(irq_mask_i), .irq_ack_i(irq_ack_i), .led_i(led_i),
    .brightness_i(brightness_i), .soc_rst_o(soc_rst_o), .btn_o(btn_o),
    .btn_rise_o(btn_rise_o), .irq_pending_o(irq_pending_o), .irq_o(irq_o),
    .sw_o(sw_o), .sw_change_o(sw_change_o), .led_o(led_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    btn_i = '0; sw_i = '0; irq_mask_i = '0; irq_ack_i = '0;
    led_i = '0; brightness_i = '0;
    cyc(3);
    n_total++;
    if ({soc_rst_o, btn_o, btn_rise_o, irq_pending_o, irq_o, sw_o, sw_change_o, led_o} !== 17'h10000)
      $display("FAIL reset_state got %h exp %h",
               {soc_rst_o, btn_o, btn_rise_o, irq_pending_o, irq_o, sw_o, sw_change_o, led_o}, 17'h10000);
    else n_pass++;
    rst_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_total++;
      if (soc_rst_o !== (i < 8)) $display("FAIL hold_%0d got %b exp %b", i, soc_rst_o, (i < 8));
      else n_pass++;
    end
    cyc(2);
    rst_i = 1'b1;
    led_i = 4'hf; brightness_i = 3'd7;
    cyc();
    rst_i = 1'b0;
    cyc(5);
    rst_i = 1'b1;
    cyc();
    n_total++;
    if ({soc_rst_o, led_o} !== 5'h10) $display("FAIL mid_hold_reset got %h exp %h", {soc_rst_o, led_o}, 5'h10);
    else n_pass++;
    led_i = '0; brightness_i = '0;
    rst_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_total++;
      if (soc_rst_o !== (i < 8)) $display("FAIL rehold_%0d got %b exp %b", i, soc_rst_o, (i < 8));
      else n_pass++;
    end
  endtask

  task automatic test_btn_press;
    irq_mask_i = 2'b01;
    btn_i = 2'b01;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      n_total++;
      if ({btn_o[0], btn_rise_o[0], irq_pending_o[0]} !== {(i >= 6), (i == 6), (i >= 6)})
        $display("FAIL press_%0d got %b exp %b", i, {btn_o[0], btn_rise_o[0], irq_pending_o[0]},
                 {(i >= 6), (i == 6), (i >= 6)});
      else n_pass++;
    end
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL irq_masked_on got %b exp 1", irq_o);
    else n_pass++;
    irq_mask_i = 2'b00;
    #1;
    n_total++;
    if ({irq_o, irq_pending_o} !== 3'b001) $display("FAIL irq_mask_off got %b exp 001", {irq_o, irq_pending_o});
    else n_pass++;
  endtask

  task automatic test_glitch;
    btn_i[1] = 1'b1;
    cyc(3);
    btn_i[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_total++;
      if ({btn_o[1], btn_rise_o[1], irq_pending_o[1]} !== 3'b000)
        $display("FAIL glitch_%0d got %b exp 000", i, {btn_o[1], btn_rise_o[1], irq_pending_o[1]});
      else n_pass++;
    end
  endtask

  task automatic test_ack;
    irq_mask_i = 2'b01;
    irq_ack_i = 2'b01;
    cyc();
    irq_ack_i = 2'b00;
    n_total++;
    if ({irq_pending_o[0], irq_o} !== 2'b00) $display("FAIL ack_clear got %b exp 00", {irq_pending_o[0], irq_o});
    else n_pass++;
    btn_i[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      n_total++;
      if ({btn_o[0], btn_rise_o[0], irq_pending_o[0]} !== {(i < 6), 1'b0, 1'b0})
        $display("FAIL release_%0d got %b exp %b", i, {btn_o[0], btn_rise_o[0], irq_pending_o[0]},
                 {(i < 6), 2'b00});
      else n_pass++;
    end
    btn_i[0] = 1'b1;
    cyc(6);
    n_total++;
    if ({btn_rise_o[0], irq_pending_o[0]} !== 2'b11) $display("FAIL repress got %b exp 11", {btn_rise_o[0], irq_pending_o[0]});
    else n_pass++;
    irq_ack_i = 2'b01;
    cyc();
    irq_ack_i = 2'b00;
    n_total++;
    if ({btn_rise_o[0], irq_pending_o[0], irq_o} !== 3'b011)
      $display("FAIL ack_vs_set got %b exp 011", {btn_rise_o[0], irq_pending_o[0], irq_o});
    else n_pass++;
    irq_ack_i = 2'b01;
    cyc();
    irq_ack_i = 2'b00;
    n_total++;
    if ({irq_pending_o, irq_o} !== 3'b000) $display("FAIL ack_alone got %b exp 000", {irq_pending_o, irq_o});
    else n_pass++;
  endtask

  task automatic test_switch;
    sw_i = 4'b1010;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      n_total++;
      if ({sw_o, sw_change_o} !== {((i >= 6) ? 4'b1010 : 4'b0000), (i == 6)})
        $display("FAIL sw_%0d got %b exp %b", i, {sw_o, sw_change_o},
                 {((i >= 6) ? 4'b1010 : 4'b0000), (i == 6)});
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) sw_i[0] = ~sw_i[0];
      cyc();
      n_total++;
      if ({sw_o, sw_change_o} !== 5'b10100) $display("FAIL sw_toggle_%0d got %b exp 10100", i, {sw_o, sw_change_o});
      else n_pass++;
    end
  endtask

  task automatic test_pwm;
    int on_cnt;
    led_i = 4'b1111;
    brightness_i = 3'd3;
    cyc(2);
    on_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (led_o === 4'b1111) on_cnt++;
      else if (led_o !== 4'b0000) $display("FAIL pwm3_shape got %b exp 0000 or 1111", led_o);
    end
    n_total++;
    if (on_cnt !== 3) $display("FAIL pwm3_on_time got %0d exp 3", on_cnt);
    else n_pass++;
    brightness_i = 3'd0;
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_total++;
      if (led_o !== 4'b0000) $display("FAIL pwm0_%0d got %b exp 0000", i, led_o);
      else n_pass++;
    end
    brightness_i = 3'd7;
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_total++;
      if (led_o !== 4'b1111) $display("FAIL pwm7_%0d got %b exp 1111", i, led_o);
      else n_pass++;
    end
    led_i = 4'b0101;
    cyc();
    n_total++;
    if (led_o !== 4'b0101) $display("FAIL led_gate got %b exp 0101", led_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_btn_press();
    test_glitch();
    test_ack();
    test_switch();
    test_pwm();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/board_io_conditioner.md
# board_io_conditioner

Parametrised board-level I/O front end between FPGA pins and the sigma SoC, generalising the Nexys4 DDR top-level glue to N buttons, M switches and L LEDs. Synchronises and debounces raw buttons and switches, generates per-button edge interrupts with mask/ack, stretches the SoC reset, and drives LEDs through a PWM brightness stage. Sits in a board top between the pins/PLL and the `sigma` instance (`irq_btn_i`, `gpio_bi`, `gpio_bo`).

## Interface
- NUM_BTN, 5, number of push-button channels (≥1)
- NUM_SW, 16, number of slide-switch channels (≥1)
- NUM_LED, 16, number of LED channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per input (≥2)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a change (≥1; 10 ms at 100 MHz)
- RST_HOLD_CYCLES, 16, cycles `soc_rst_o` is held after `rst_i` drops (≥1)
- PWM_BITS, 8, width of PWM counter and brightness (≥1)

Ports:
- clk_i  in  1  single system clock (PLL output)
- rst_i  in  1  synchronous, active-high reset
- btn_i  in  NUM_BTN  raw asynchronous buttons
- sw_i  in  NUM_SW  raw asynchronous switches
- irq_mask_i  in  NUM_BTN  1 = channel may raise `irq_o`
- irq_ack_i  in  NUM_BTN  1-cycle clear of pending bit
- led_i  in  NUM_LED  LED on/off request from SoC
- brightness_i  in  PWM_BITS  global LED duty
- soc_rst_o  out  1  stretched reset to SoC
- btn_o  out  NUM_BTN  debounced button level
- btn_rise_o  out  NUM_BTN  1-cycle pulse on debounced 0→1
- irq_pending_o  out  NUM_BTN  sticky pending flags
- irq_o  out  1  OR of (irq_pending_o & irq_mask_i)
- sw_o  out  NUM_SW  debounced switch level
- sw_change_o  out  1  1-cycle pulse when any sw_o bit changes
- led_o  out  NUM_LED  PWM-modulated LED drive

## Operation
- Reset (rst_i=1 at an edge): all synchroniser flops, debounce counters, stable states, pending flags, PWM counter, led_o cleared to 0; soc_rst_o=1; all pulse outputs 0. Applies mid-debounce, mid-hold, mid-PWM.
- Synchroniser: SYNC_STAGES flop chain per btn/sw bit; only last stage feeds debounce.
- Debounce, per channel: counter width clog2(DEBOUNCE_CYCLES+1). Cycle where sync≠stable: counter+1; when counter reaches DEBOUNCE_CYCLES-1 on such a cycle, stable←sync and counter←0. Cycle where sync=stable: counter←0. Glitch shorter than DEBOUNCE_CYCLES never changes stable.
- btn_rise_o[n]=1 for exactly the cycle after btn_o[n] goes 0→1 is registered (registered alongside btn_o); no pulse on 1→0.
- Pending: set on btn_rise; cleared by irq_ack_i[n]; set and ack same cycle → stays 1 (set wins). Mask only gates irq_o, never pending. irq_o is combinational from registered pending and mask.
- sw_change_o: registered, high one cycle when any sw_o bit updates.
- Reset stretch: hold counter counts cycles with rst_i=0; soc_rst_o falls when count reaches RST_HOLD_CYCLES; rst_i reassertion restarts from 0.
- PWM: free-running PWM_BITS counter, wraps all-ones→0. led_o[i] registered = led_i[i] & (brightness_i==all-ones | pwm_cnt<brightness_i). brightness 0 → off; all-ones → constant on.

## Timing
- Input edge to btn_o/sw_o change: SYNC_STAGES + DEBOUNCE_CYCLES cycles (input stable throughout).
- btn_rise_o and irq_pending_o set: same cycle btn_o rises. irq_o follows combinationally.
- Ack: pending clears the cycle after irq_ack_i sampled.
- soc_rst_o falls RST_HOLD_CYCLES edges after first edge sampling rst_i=0.
- led_i/brightness_i to led_o: 1 cycle. PWM period 2^PWM_BITS cycles; on-time = brightness_i cycles (except all-ones).

## Test plan
Bench params: NUM_BTN=2, NUM_SW=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, PWM_BITS=3.
- Release rst_i after 3 cycles → soc_rst_o stays 1 exactly 8 cycles, then 0; reassert rst_i at hold cycle 5 → counter restarts, outputs all 0.
- btn_i[0] 0→1 held → btn_o[0] rises 6 cycles later, btn_rise_o[0] single pulse, irq_pending_o[0]=1; irq_mask_i=2'b01 → irq_o=1; mask 0 → irq_o=0, pending still 1.
- btn_i[1] glitch high 3 cycles → btn_o[1] stays 0, no pulse, no pending.
- irq_ack_i[0] same cycle as new btn_rise_o[0] → pending stays 1; ack alone next → pending 0 one cycle later.
- sw_i 4'b0000→4'b1010 → sw_o=4'b1010 after 6 cycles, sw_change_o one pulse; switch toggling every 2 cycles → sw_o unchanged.
- led_i=4'b1111, brightness 3 → led_o high 3 of every 8 cycles; brightness 0 → constant 0; brightness 7 → constant 1.
